// File: rtl/dht11_pkg.sv
// Shared constants for the DHT11 UART reporter: reading field slices, line
// template characters, FSM state encoding and ASCII helpers.
package dht11_pkg;

  localparam int HUM_INT_MSB = 31;
  localparam int HUM_INT_LSB = 24;
  localparam int HUM_DEC_MSB = 23;
  localparam int HUM_DEC_LSB = 16;
  localparam int TMP_INT_MSB = 15;
  localparam int TMP_INT_LSB = 8;
  localparam int TMP_DEC_MSB = 7;
  localparam int TMP_DEC_LSB = 0;

  localparam int LINE_LEN = 19;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    CONV_H,
    CONV_T,
    LOAD,
    SHIFT
  } state_t;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_0 + {4'd0, d};
  endfunction

  // Sensor decimals are a single digit; anything larger is shown as '9'.
  function automatic logic [7:0] dec_ascii(input logic [7:0] v);
    return (v > 8'd9) ? ASCII_9 : (ASCII_0 + v);
  endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per cycle.
// done pulses 8 cycles after start; bcd holds the result until the next start.
import dht11_pkg::*;

module bin8_to_bcd (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  // {hundreds, tens, units, binary remainder}
  logic [19:0] sh;
  logic [19:0] sh_adj;
  logic [3:0]  cnt;

  always_comb begin
    sh_adj = sh;
    if (sh[11:8] >= 4'd5)  sh_adj[11:8]  = sh[11:8]  + 4'd3;
    if (sh[15:12] >= 4'd5) sh_adj[15:12] = sh[15:12] + 4'd3;
    if (sh[19:16] >= 4'd5) sh_adj[19:16] = sh[19:16] + 4'd3;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= {12'd0, bin};
        cnt <= 4'd8;
      end else if (cnt != 4'd0) begin
        sh  <= {sh_adj[18:0], 1'b0};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) done <= 1'b1;
      end
    end
  end

  assign bcd = sh[19:8];

endmodule

// File: rtl/dht11_uart_reporter.sv
// Formats each new DHT11 reading as "H=hhh.d% T=ttt.dC\r\n" and sends it as 8N1 UART.
// Optional periodic resend of the last line is enabled by defining DHT_REPORT_PERIODIC_EN.
//
// state  | meaning
// IDLE   | waiting for a new stable reading (or the resend period)
// CONV_H | humidity integer in the BCD converter
// CONV_T | temperature integer in the BCD converter
// LOAD   | fetch template byte idx into the shifter
// SHIFT  | clock out start, 8 data and stop bits
import dht11_pkg::*;

module dht11_uart_reporter #(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD             = 115200,
  parameter int REPORT_PERIOD_MS = 5000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] reading,
  output logic        uart_tx,
  output logic        busy,
  output logic        line_done
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int DIV_W   = $clog2(BIT_DIV + 1);
  localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

  state_t state, state_nxt;

  logic [31:0] r0, r1, last_sent, pend_word, start_word;
  logic [23:0] snap;
  logic        pending, stable, fresh, start_line;
  logic [11:0] hum_bcd, tmp_bcd, bcd_val;
  logic        bcd_start, bcd_done;
  logic [7:0]  bcd_bin, line_byte;
  logic [4:0]  idx;
  logic [9:0]  tx_shift;
  logic [3:0]  bit_cnt;
  logic [DIV_W-1:0] baud_cnt;
  logic        byte_done, period_hit;

  assign stable = (r0 == r1);
  assign fresh  = stable && (r1 != '0) && (r1 != last_sent);

`ifdef DHT_REPORT_PERIODIC_EN
  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int TICK_W = $clog2(MS_DIV + 1);
  localparam int MS_W   = $clog2(REPORT_PERIOD_MS + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [MS_W-1:0]   ms_cnt;

  assign period_hit = (ms_cnt == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= TICK_W'(MS_DIV - 1);
      ms_cnt   <= MS_W'(REPORT_PERIOD_MS);
    end else if (start_line) begin
      tick_cnt <= TICK_W'(MS_DIV - 1);
      ms_cnt   <= MS_W'(REPORT_PERIOD_MS);
    end else if (state == IDLE && !period_hit) begin
      if (tick_cnt == '0) begin
        tick_cnt <= TICK_W'(MS_DIV - 1);
        ms_cnt   <= ms_cnt - 1'b1;
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end
`else
  assign period_hit = 1'b0;
`endif

  // A value that went stable during the previous line wins over a fresh one.
  always_comb begin
    start_line = 1'b0;
    start_word = r1;
    if (state == IDLE) begin
      if (pending) begin
        start_line = 1'b1;
        start_word = pend_word;
      end else if (fresh) begin
        start_line = 1'b1;
      end else if (period_hit && last_sent != '0) begin
        start_line = 1'b1;
        start_word = last_sent;
      end
    end
  end

  assign byte_done = (state == SHIFT) && (baud_cnt == '0) && (bit_cnt == 4'd1);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_line) state_nxt = CONV_H;
      CONV_H:  if (bcd_done) state_nxt = CONV_T;
      CONV_T:  if (bcd_done) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (byte_done) state_nxt = (idx == LAST_IDX) ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_done = byte_done && (idx == LAST_IDX);
    busy      = (state != IDLE) && !line_done;
    bcd_start = start_line || (state == CONV_H && bcd_done);
    bcd_bin   = (state == IDLE) ? start_word[HUM_INT_MSB:HUM_INT_LSB]
                                : snap[TMP_INT_MSB:TMP_INT_LSB];
  end

  bin8_to_bcd u_bcd (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (bcd_start),
    .bin     (bcd_bin),
    .done    (bcd_done),
    .bcd     (bcd_val)
  );

  always_comb begin
    line_byte = LF;
    case (idx)
      5'd0:  line_byte = "H";
      5'd1:  line_byte = "=";
      5'd2:  line_byte = digit_ascii(hum_bcd[11:8]);
      5'd3:  line_byte = digit_ascii(hum_bcd[7:4]);
      5'd4:  line_byte = digit_ascii(hum_bcd[3:0]);
      5'd5:  line_byte = ".";
      5'd6:  line_byte = dec_ascii(snap[HUM_DEC_MSB:HUM_DEC_LSB]);
      5'd7:  line_byte = "%";
      5'd8:  line_byte = " ";
      5'd9:  line_byte = "T";
      5'd10: line_byte = "=";
      5'd11: line_byte = digit_ascii(tmp_bcd[11:8]);
      5'd12: line_byte = digit_ascii(tmp_bcd[7:4]);
      5'd13: line_byte = digit_ascii(tmp_bcd[3:0]);
      5'd14: line_byte = ".";
      5'd15: line_byte = dec_ascii(snap[TMP_DEC_MSB:TMP_DEC_LSB]);
      5'd16: line_byte = "C";
      5'd17: line_byte = CR;
      default: line_byte = LF;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r0        <= '0;
      r1        <= '0;
      last_sent <= '0;
      pend_word <= '0;
      pending   <= 1'b0;
      snap      <= '0;
      hum_bcd   <= '0;
      tmp_bcd   <= '0;
      idx       <= '0;
      tx_shift  <= '1;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
    end else begin
      r0 <= reading;
      r1 <= r0;

      // snap is frozen for the whole line; later changes only update pending.
      if (start_line) begin
        snap      <= start_word[23:0];
        last_sent <= start_word;
        pending   <= 1'b0;
      end else if (state != IDLE && stable) begin
        if (r1 != '0 && r1 != last_sent) begin
          pending   <= 1'b1;
          pend_word <= r1;
        end else if (r1 == last_sent) begin
          pending   <= 1'b0;
        end
      end

      if (state == CONV_H && bcd_done) hum_bcd <= bcd_val;
      if (state == CONV_T && bcd_done) begin
        tmp_bcd <= bcd_val;
        idx     <= '0;
      end

      if (state == LOAD) begin
        tx_shift <= {1'b1, line_byte, 1'b0};
        bit_cnt  <= 4'd10;
        baud_cnt <= DIV_W'(BIT_DIV - 1);
      end else if (state == SHIFT) begin
        if (baud_cnt == '0) begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          bit_cnt  <= bit_cnt - 4'd1;
          baud_cnt <= DIV_W'(BIT_DIV - 1);
          if (bit_cnt == 4'd1 && idx != LAST_IDX) idx <= idx + 5'd1;
        end else begin
          baud_cnt <= baud_cnt - 1'b1;
        end
      end
    end
  end

  assign uart_tx = tx_shift[0];

endmodule

// File: doc/dht11_uart_reporter.md
Name: dht11_uart_reporter

Overview:
Downstream consumer of the DHT11 reader's validated 32-bit measurement word. It formats each new reading as a fixed-width ASCII line and sends it out as 8N1 UART serial.
- Line format: "H=hhh.d% T=ttt.dC\r\n", 19 bytes, leading zeros kept.
- Lets a host or terminal log humidity and temperature with no software on the FPGA side.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 115200, UART bit rate.
- BIT_DIV, CLK_FREQ/BAUD (434 at defaults), sys_clk cycles per UART bit; derived localparam, not overridden.
- REPORT_PERIOD_MS, 5000, periodic resend interval; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- reading  in  32  reader output word: [31:24] humidity integer, [23:16] humidity decimal, [15:8] temperature integer, [7:0] temperature decimal.
- uart_tx  out  1  serial output, 8N1, LSB first, idle high.
- busy  out  1  high while a line is being converted or transmitted.
- line_done  out  1  one-cycle pulse after the stop bit of the last byte (LF).

Behaviour:
- Reset values: uart_tx=1, busy=0, line_done=0, last_sent=0, pending=0, FSM in IDLE.
- Reset is asynchronous and aborts any transfer; uart_tx returns high immediately.
- Input capture:
  - reading comes from the 1 MHz-divided domain, so it passes through two sys_clk flops (r0, r1).
  - A candidate is accepted only when r0==r1 (stable for 2 cycles), r1!=last_sent and r1!=0.
  - Zero means "no valid data yet" and is never reported.
- FSM states:
  - IDLE: on an accepted candidate, copy it to snap and last_sent, clear pending, set busy, go to CONV_H.
  - CONV_H: start bin8_to_bcd on snap[31:24]; wait for its done pulse (8 cycles), store 3 BCD digits, go to CONV_T.
  - CONV_T: same for snap[15:8], then go to LOAD with byte index 0.
  - LOAD: select byte[idx] from the line template, load the shifter with {stop=1, data, start=0}, go to SHIFT.
  - SHIFT: shift one bit every BIT_DIV cycles, 10 bits total. Afterwards, if idx<18 then increment idx and go to LOAD; else pulse line_done and go to IDLE.
  - busy drops in the cycle line_done pulses.
- Byte map:
  - "H=", hum hundreds, tens, units, ".", hum decimal, "% T=", temp hundreds, tens, units, ".", temp decimal, "C", 0x0D, 0x0A.
  - Digit ASCII = 0x30 + BCD value.
  - A decimal byte greater than 9 is clamped to '9'.
- Timing:
  - Line latency from acceptance to start bit = 2 + 8 + 8 + 1 cycles.
  - One byte takes 10*BIT_DIV = 4340 cycles; the full line takes 82460 cycles plus overhead.
- Updates during transmission:
  - snap is frozen, so the line in flight is never corrupted.
  - A stable change sets pending; on return to IDLE the newest stable value is sent.
  - Intermediate values are dropped, not queued.
- Repeated identical readings are not resent.

Optional Feature:
- Macro DHT_REPORT_PERIODIC_EN.
- Defined: a millisecond counter runs in IDLE. When it reaches REPORT_PERIOD_MS, the last_sent value is resent, provided it is non-zero. The counter restarts on every line start.
- Undefined: a line is sent only on a change of reading; the counter logic is absent.

Decomposition:
- Shared package dht11_pkg holds:
  - field bit-slice constants (HUM_INT_MSB, etc.);
  - LINE_LEN=19;
  - ASCII constants (CR, LF, ASCII_0);
  - FSM state encoding.
- Natural sub-module: bin8_to_bcd.
  - Sequential double-dabble, start/done handshake.
  - Input 8 bits, output 12 bits (hundreds/tens/units).
  - Done 8 cycles after start.
- UART shifter stays inline.

Test Plan:
- Reading 0x2D00_1701 held stable → uart_tx decodes "H=045.0% T=023.1C\r\n"; each bit lasts 434±1 cycles; line_done pulses once; busy falls in the same cycle.
- Reading 0x0000_0000 after reset → no start bit and busy stays 0 for 200000 cycles.
- Reading 0x5A00_FF09 → "H=090.0% T=255.9C\r\n" (max integer value, decimal 9); reading 0x0100_000C → temperature decimal clamped to '9'.
- Reading changes 0x2D00_1701 → 0x2E00_1701 → 0x2F00_1701 during line 1 → exactly two lines sent, the second showing H=047.0; the 0x2E value is never sent.
- Single-cycle glitch on reading, then revert to last_sent → no new line.
- rst asserted mid-byte 7 → uart_tx=1 and busy=0 immediately. After release, the same non-zero reading is sent again in full, because last_sent was cleared.
